ps2_host_tx: RTL and testbench
==============================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter RTS_CYCLES, default 5000, the number of clk cycles ps2c is held low for request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum number of clk cycles allowed between device falling edges before abort.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_ps2, input, 1, a one-cycle request to send din.
REQ-006 SHALL have port din, input, 8, the command byte (e.g. 0xED LED set).
REQ-007 SHALL have port ps2c, inout, 1, the open-drain PS/2 clock: driven 0 or Z, never 1.
REQ-008 SHALL have port ps2d, inout, 1, the open-drain PS/2 data line: driven 0 or Z, never 1.
REQ-009 SHALL have port tx_idle, output, 1, high only in IDLE.
REQ-010 SHALL have port rx_en, output, 1, equal to tx_idle; it gates the existing receiver.
REQ-011 SHALL have port tx_done_tick, output, 1, a one-cycle pulse at the end of a transfer.
REQ-012 SHALL have port tx_err, output, 1, status valid with tx_done_tick: 1 = NACK or timeout; held until the next wr_ps2 is accepted.

Function
REQ-013 ps2c SHALL be sampled into an 8-bit shift register; the filtered clock goes 1 when all 8 samples are 1, goes 0 when all 8 are 0, and otherwise holds.
REQ-014 fall_tick SHALL pulse for one cycle on a filtered 1->0 transition.
REQ-015 The FSM SHALL have the states IDLE, RTS, START, DATA, STOP, ACK.
REQ-016 In IDLE, on wr_ps2=1:
- load pkt[8:0] = {~^din, din}, i.e. odd parity;
- load cnt = RTS_CYCLES-1;
- clear tx_err;
- go to RTS.
REQ-017 In RTS, ps2c SHALL be driven 0 and ps2d SHALL be driven 0 from the RTS entry cycle onward; cnt decrements; at cnt=0 release ps2c and go to START.
REQ-018 In START, ps2d SHALL be held 0 (start bit); on fall_tick set n=8, place pkt[0] on ps2d and go to DATA.
REQ-019 In DATA, ps2d SHALL be 0 when pkt[0]=0 and Z otherwise; on fall_tick shift pkt right.
- If n=0, go to STOP.
- Otherwise decrement n.
- In total, 8 data bits LSB first plus the parity bit are sent.
REQ-020 In STOP, ps2d SHALL be released (stop bit = 1); on fall_tick go to ACK.
REQ-021 In ACK, on fall_tick sample ps2d:
- 0 means ACK, tx_err=0;
- 1 means NACK, tx_err=1;
- then assert tx_done_tick and go to IDLE.
REQ-022 In START, DATA, STOP and ACK a watchdog SHALL reload to TIMEOUT_CYCLES-1 on each fall_tick.
- On expiry: release both lines, set tx_err=1, pulse tx_done_tick, go to IDLE.
REQ-023 wr_ps2 outside IDLE SHALL be ignored; din is captured only at acceptance.
REQ-024 Outside RTS..DATA, ps2c and ps2d SHALL be Z.
REQ-025 Latency: wr_ps2 to ps2c low is 1 cycle; the clock is held low for exactly RTS_CYCLES cycles.

Reset
REQ-026 reset=1 SHALL asynchronously force:
- state=IDLE, ps2c=Z, ps2d=Z;
- tx_idle=1, rx_en=1, tx_done_tick=0, tx_err=0;
- filter register all 1s, cnt=0, n=0, pkt=0.
REQ-027 A reset mid-transfer SHALL release both lines immediately and produce no tx_done_tick.

Structure
REQ-028 The state encoding, RTS_CYCLES and TIMEOUT_CYCLES defaults and the 8-bit filter width SHALL live in shared package ps2_pkg, reused by the receiver.
REQ-029 The filter and edge detect SHALL be sub-module ps2_clk_filter (clk, reset, ps2c_in -> ps2c_f, fall_tick), shareable with the receiver.

Verification
REQ-030 Reset: hold reset mid-DATA -> ps2c=Z and ps2d=Z within the same cycle; tx_idle=1; no tx_done_tick.
REQ-031 RTS timing: with RTS_CYCLES=50, pulse wr_ps2 -> ps2c low for exactly 50 cycles, then Z with ps2d=0.
REQ-032 Byte send: din=0xED, device model clocks at 10 kHz and pulls ps2d low at the ack edge -> sampled bits 0,1,0,1,1,0,1,1,1,1,1 (start, data LSB first, parity=1, stop); tx_done_tick=1 with tx_err=0.
REQ-033 NACK: din=0xF4, device leaves ps2d high at the ack edge -> parity bit=0; tx_done_tick with tx_err=1.
REQ-034 Timeout: with TIMEOUT_CYCLES=200, the device stops clocking after 3 edges -> 200 cycles later lines are Z, tx_err=1, one tx_done_tick, tx_idle=1.
REQ-035 Busy request and glitch rejection: wr_ps2 during DATA with din=0x00 -> the transmitted byte is unchanged; a 5-cycle ps2c glitch produces no fall_tick.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the receiver.
package ps2_pkg;

    // Host-to-device transfer phases
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RTS   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4,
        ST_ACK   = 3'd5
    } ps2_state_e;

    localparam int unsigned RTS_CYCLES_DEF     = 5000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;
    localparam int unsigned FILTER_W           = 8;
    localparam int unsigned DATA_W             = 8;
    localparam int unsigned PKT_W              = DATA_W + 1;

    // Odd parity bit for a data byte
    function automatic logic odd_parity(input logic [DATA_W-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Debounces the PS/2 clock and flags filtered falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic ps2c_f,
    output logic fall_tick
);

    logic [FILTER_W-1:0] r_filter;
    logic                r_f;
    logic                r_fall;
    logic                w_f_next;

    // Filtered level flips only on a full window of agreeing samples
    always_comb begin
        w_f_next = r_f;
        if (&r_filter) begin
            w_f_next = 1'b1;
        end else if (~|r_filter) begin
            w_f_next = 1'b0;
        end
    end

    // Sample shift register, filtered level and falling-edge pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filter <= '1;
            r_f      <= 1'b1;
            r_fall   <= 1'b0;
        end else begin
            r_filter <= {ps2c_in, r_filter[FILTER_W-1:1]};
            r_f      <= w_f_next;
            r_fall   <= r_f & ~w_f_next;
        end
    end

    assign ps2c_f    = r_f;
    assign fall_tick = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with request-to-send and watchdog.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_ps2,
    input  logic [DATA_W-1:0] din,
    inout  wire               ps2c,
    inout  wire               ps2d,
    output logic              tx_idle,
    output logic              rx_en,
    output logic              tx_done_tick,
    output logic              tx_err
);

    localparam int unsigned CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned N_W     = 4;

    ps2_state_e         r_state, w_state_next;
    logic [PKT_W-1:0]   r_pkt, w_pkt_next;
    logic [N_W-1:0]     r_n, w_n_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_err, w_err_next;
    logic               r_done, w_done_next;
    logic               r_idle, w_idle_next;
    logic               r_c_oe, w_c_oe_next;
    logic               r_d_oe, w_d_oe_next;
    logic               w_ps2c_f;
    logic               w_fall_tick;
    logic               w_fall;
    logic               w_ps2d_in;

    ps2_clk_filter u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c),
        .ps2c_f    (w_ps2c_f),
        .fall_tick (w_fall_tick)
    );

    // A falling edge is only honoured once the filtered clock is low
    assign w_fall    = w_fall_tick & ~w_ps2c_f;
    assign w_ps2d_in = ps2d;

    // Next-state, shift/count and drive-enable logic
    always_comb begin
        w_state_next = r_state;
        w_pkt_next   = r_pkt;
        w_n_next     = r_n;
        w_cnt_next   = r_cnt;
        w_err_next   = r_err;
        w_done_next  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (wr_ps2) begin
                    w_pkt_next   = {odd_parity(din), din};
                    w_cnt_next   = CNT_W'(RTS_CYCLES - 1);
                    w_err_next   = 1'b0;
                    w_state_next = ST_RTS;
                end
            end
            ST_RTS: begin
                if (r_cnt == '0) begin
                    w_cnt_next   = CNT_W'(TIMEOUT_CYCLES - 1);
                    w_state_next = ST_START;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            ST_START: begin
                if (w_fall) begin
                    w_n_next     = N_W'(DATA_W);
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_pkt_next = {1'b0, r_pkt[PKT_W-1:1]};
                    if (r_n == '0) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_n_next = r_n - N_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_fall) begin
                    w_err_next   = w_ps2d_in;
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Watchdog while the device owns the clock
        if (r_state inside {ST_START, ST_DATA, ST_STOP, ST_ACK}) begin
            if (w_fall) begin
                w_cnt_next = CNT_W'(TIMEOUT_CYCLES - 1);
            end else if (r_cnt == '0) begin
                w_err_next   = 1'b1;
                w_done_next  = 1'b1;
                w_state_next = ST_IDLE;
            end else begin
                w_cnt_next = r_cnt - CNT_W'(1);
            end
        end

        w_idle_next = (w_state_next == ST_IDLE);
        w_c_oe_next = (w_state_next == ST_RTS);
        w_d_oe_next = (w_state_next == ST_RTS) || (w_state_next == ST_START) ||
                      ((w_state_next == ST_DATA) && !w_pkt_next[0]);
    end

    // State and output registers; reset releases both lines at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pkt   <= '0;
            r_n     <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b1;
            r_c_oe  <= 1'b0;
            r_d_oe  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pkt   <= w_pkt_next;
            r_n     <= w_n_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
            r_done  <= w_done_next;
            r_idle  <= w_idle_next;
            r_c_oe  <= w_c_oe_next;
            r_d_oe  <= w_d_oe_next;
        end
    end

    assign ps2c         = r_c_oe ? 1'b0 : 1'bz;
    assign ps2d         = r_d_oe ? 1'b0 : 1'bz;
    assign tx_idle      = r_idle;
    assign rx_en        = r_idle;
    assign tx_done_tick = r_done;
    assign tx_err       = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a device model and frame reference.
module tb_ps2_host_tx;

    localparam int unsigned RTS_N = 50;
    localparam int unsigned TO_N  = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;
    wire        ps2c_w;
    wire        ps2d_w;
    logic       tx_idle, rx_en, tx_done_tick, tx_err;

    pullup (ps2c_w);
    pullup (ps2d_w);
    assign ps2c_w = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d_w = dev_d_low ? 1'b0 : 1'bz;

    ps2_host_tx #(
        .RTS_CYCLES     (RTS_N),
        .TIMEOUT_CYCLES (TO_N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c_w),
        .ps2d         (ps2d_w),
        .tx_idle      (tx_idle),
        .rx_en        (rx_en),
        .tx_done_tick (tx_done_tick),
        .tx_err       (tx_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   t_done = 0;
    logic exp_err = 1'b0;
    logic model_err = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Expected frame: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
        f[9]  = (($countones(b) % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle observer of status outputs and line ownership
    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                model_err = 1'b0;
            end else begin
                check("rx_en_eq_idle", rx_en, tx_idle);
                if (tx_idle) begin
                    check("c_released", ps2c_w, !dev_c_low);
                    check("d_released", ps2d_w, !dev_d_low);
                end
                if (tx_idle && !tx_done_tick) check("err_hold", tx_err, model_err);
                if (tx_done_tick) begin
                    if (done_cnt >= exp_done) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done got done #%0d expected none (cycle %0d)", done_cnt + 1, cyc);
                    end else begin
                        check("tx_err_at_done", tx_err, exp_err);
                        check("idle_at_done", tx_idle, 1'b1);
                    end
                    done_cnt++;
                    t_done = cyc;
                    model_err = tx_err;
                end
            end
        end
    endtask

    // Device: clocks n_edges pulses, samples data before each fall, acks on request
    task automatic device(input int hp, input bit ack, input bit glitch, input int n_edges,
                          output logic [10:0] got, output int t_fall);
        got = '0;
        t_fall = cyc;
        repeat (20) @(posedge clk);
        if (glitch) begin
            dev_c_low = 1'b1;
            repeat (5) @(posedge clk);
            dev_c_low = 1'b0;
            repeat (20) @(posedge clk);
        end
        for (int k = 0; k < n_edges; k++) begin
            repeat (hp - 1) @(posedge clk);
            @(negedge clk);
            if (k < 11) got[k] = ps2d_w;
            @(posedge clk);
            dev_c_low = 1'b1;
            t_fall = cyc;
            if (k == 10 && ack) dev_d_low = 1'b1;
            repeat (hp) @(posedge clk);
            dev_c_low = 1'b0;
            if (k == 11) dev_d_low = 1'b0;
        end
    endtask

    // One host transfer: request, RTS timing, device frame, completion
    task automatic send(input logic [7:0] b, input bit ack, input int hp, input bit glitch,
                        input bit busy, input int n_edges, input bit expect_done,
                        output logic [10:0] got, output int t_fall);
        int d0;
        int lowc;
        d0 = done_cnt;
        exp_err = (n_edges < 12) ? 1'b1 : !ack;
        if (expect_done) exp_done++;
        @(negedge clk);
        din = b;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din = 8'($urandom);
        check("rts_latency", ps2c_w, 1'b0);
        lowc = 1;
        for (int i = 0; i < int'(RTS_N) + 20; i++) begin
            @(negedge clk);
            if (ps2c_w !== 1'b0) break;
            lowc++;
        end
        check("rts_len", lowc, RTS_N);
        check("start_bit_d", ps2d_w, 1'b0);
        fork
            device(hp, ack, glitch, n_edges, got, t_fall);
            begin
                if (busy) begin
                    repeat (hp * 6) @(negedge clk);
                    din = 8'h00;
                    wr_ps2 = 1'b1;
                    @(negedge clk);
                    wr_ps2 = 1'b0;
                end
            end
        join
        if (n_edges == 12) check("frame_vs_model", got, model_frame(b));
        if (expect_done) begin
            for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
            repeat (4) @(negedge clk);
            check("one_done", done_cnt - d0, 1);
        end
    endtask

    logic [10:0] got;
    int          tf;

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        check("rst_idle", tx_idle, 1'b1);
        check("rst_rx_en", rx_en, 1'b1);
        check("rst_done", tx_done_tick, 1'b0);
        check("rst_err", tx_err, 1'b0);
        check("rst_c", ps2c_w, 1'b1);
        check("rst_d", ps2d_w, 1'b0 == 1'b0 ? ps2d_w : 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Directed: 0xED acknowledged, with a busy request during DATA and a glitch in START
        send(8'hED, 1'b1, 40, 1'b1, 1'b1, 12, 1'b1, got, tf);
        check("frame_ED", got, 11'b11111011010);
        check("err_ED", tx_err, 1'b0);

        // Directed: 0xF4 not acknowledged
        send(8'hF4, 1'b0, 30, 1'b0, 1'b0, 12, 1'b1, got, tf);
        check("frame_F4", got, 11'b10111101000);
        check("err_F4", tx_err, 1'b1);

        // Directed: device stops after 3 edges
        send(8'hA5, 1'b1, 40, 1'b0, 1'b0, 3, 1'b1, got, tf);
        checks++;
        if (!((t_done - tf) >= int'(TO_N) && (t_done - tf) <= int'(TO_N) + 22)) begin
            errors++;
            $display("FAIL timeout_delay got %0d expected %0d..%0d", t_done - tf, TO_N, TO_N + 22);
        end
        check("timeout_err", tx_err, 1'b1);
        check("timeout_idle", tx_idle, 1'b1);
        check("timeout_c", ps2c_w, 1'b1);
        check("timeout_d", ps2d_w, 1'b1);

        // Random transfers
        for (int t = 0; t < 10; t++) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(20, 60)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12, 1'b1, got, tf);
        end

        // Reset in the middle of DATA while a zero bit is driven
        send(8'h00, 1'b1, 40, 1'b0, 1'b0, 4, 1'b0, got, tf);
        check("pre_reset_d_low", ps2d_w, 1'b0);
        check("pre_reset_busy", tx_idle, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_c", ps2c_w, 1'b1);
        check("reset_d", ps2d_w, 1'b1);
        check("reset_idle", tx_idle, 1'b1);
        check("reset_done", tx_done_tick, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        tf = done_cnt;
        repeat (300) @(negedge clk);
        check("no_done_after_reset", done_cnt - tf, 0);

        // Post-reset transfer still works
        send(8'h3C, 1'b1, 25, 1'b0, 1'b0, 12, 1'b1, got, tf);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
